elevator_scheduler: RTL and testbench
=====================================

// Module: elevator_scheduler
// PURPOSE
//   Parametrised elevator controller. Manages a per-floor queue of waiting riders,
//   moves the car with a SCAN policy and exposes floor, direction and animation phase.
//   Sits between the keyboard request path and the LED / 7-segment display logic.
//   Single clock domain: movement is paced by a tick enable, not a divided clock.
// PARAMETERS
//   FLOORS  3   number of floors, 2..8
//   DEPTH   4   max riders queued per floor, 1..15; also LED bits per floor
//   PHASES  4   ticks per floor of travel, 2..4 (drives display animation)
//   FW      $clog2(FLOORS)  floor index width (derived)
//   CW      $clog2(DEPTH+1) queue count width (derived)
// PORTS
//   clk         in   1             system clock
//   rst         in   1             asynchronous, active-low reset
//   tick        in   1             one-cycle movement/boarding enable
//   req_valid   in   1             one-cycle rider request
//   req_floor   in   FW            floor of request
//   cur_floor   out  FW            current car floor
//   dir         out  2             STAY=00, UP=01, DOWN=10
//   phase       out  2             travel animation phase, 0..PHASES-1
//   pending     out  FLOORS*DEPTH  thermometer per floor: count n -> low n bits set
//   board_pulse out  1             one cycle; one rider boarded at cur_floor
//   req_drop    out  1             one cycle; request rejected
// BEHAVIOUR
//   Reset (rst=0, async): cur_floor=0, dir=STAY, phase=0, all counts 0,
//     last_dir=UP, board_pulse=0, req_drop=0. Any state, including mid-travel.
//   All outputs are registered; effects are visible the cycle after sampling.
//   Request: req_valid & req_floor<FLOORS & count<DEPTH -> count[req_floor]+1.
//     Count==DEPTH or req_floor>=FLOORS -> count unchanged, req_drop=1 next cycle.
//     Requests are accepted in every state.
//   pend_above/pend_below: OR of count!=0 over floors above/below cur_floor.
//   FSM IDLE (dir=STAY), acts only on tick:
//     count[cur_floor]!=0 -> decrement, board_pulse=1, remain IDLE.
//     else if pending in last_dir -> MOVE that way; else if pending opposite ->
//     MOVE opposite, last_dir updated; else remain IDLE. Entry: phase=0.
//   FSM MOVE (dir=UP/DOWN), acts only on tick:
//     phase<PHASES-1 -> phase+1.
//     phase==PHASES-1 -> cur_floor +/-1, phase=0; then if count[new]!=0 or no
//     pending further in dir -> IDLE (dir=STAY, last_dir kept); else stay in MOVE.
//     Direction is re-evaluated only at floor boundaries.
//   Arrival never boards; boarding takes the next IDLE tick.
//   Same cycle request + board on one floor -> net count unchanged, no drop.
//   Same cycle request with count==DEPTH-1 and board -> accepted.
//   Floor 0 / FLOORS-1 bounds: never exceeded; pending checks exclude them.
//   tick with rst asserted is ignored.
// STRUCTURE
//   Package elevator_pkg: dir_t (STAY/UP/DOWN), fsm state enum (IDLE/MOVE),
//     thermometer helper function.
//   Sub-module floor_queue: saturating up/down counter with req_drop and
//     thermometer output; instantiated FLOORS times.
//   Top: pending masks, SCAN decision and FSM.
// TESTING (FLOORS=3, DEPTH=4, PHASES=4 unless noted)
//   Reset mid-MOVE, car at floor 1, counts nonzero -> cur_floor=0, dir=STAY,
//     pending=0 immediately.
//   Idle at 0, one request floor 2, then ticks -> tick1 dir=UP; tick5 floor=1;
//     tick9 floor=2, dir=STAY; tick10 board_pulse, pending[11:8]=0.
//   Five requests floor 1 -> pending[7:4]=4'b1111, exactly one req_drop.
//   At floor 1, IDLE, last_dir=UP, requests on floors 0 and 2 -> next tick dir=UP.
//   count[cur]=2, req on cur_floor coincident with boarding tick -> count stays 2,
//     board_pulse=1, req_drop=0.
//   req_floor=3 -> req_drop=1, pending unchanged; FLOORS=8 top floor round trip.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator scheduler: direction codes,
// controller states and the per-bit thermometer decode used by the floor queues.
package elevator_pkg;

    typedef enum logic [1:0] {
        DIR_STAY = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } state_t;

    // Bit bit_idx of a thermometer code for count: the low count bits are set.
    function automatic logic therm_bit(input int count, input int bit_idx);
        return (bit_idx < count);
    endfunction

endpackage

// File: rtl/floor_queue.sv
// Rider count for one floor: saturating up/down counter with full/nonzero flags
// and a thermometer view of the count for the LED bar.
module floor_queue
    import elevator_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic             full,
    output logic             nonzero,
    output logic [DEPTH-1:0] therm
);

    logic [CW-1:0] count_q;
    logic          accept;

    assign full    = (count_q == CW'(DEPTH));
    assign nonzero = (count_q != '0);
    // A full queue refuses the request even when a rider boards the same cycle.
    assign accept  = inc && !full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (accept && !dec) begin
            count_q <= count_q + CW'(1);
        end else if (dec && !accept) begin
            count_q <= count_q - CW'(1);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_therm
        assign therm[i] = therm_bit(int'(count_q), i);
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Elevator controller: per-floor rider queues, SCAN direction choice and a
// tick-paced travel FSM driving floor, direction and animation phase.
//
// state | meaning
// IDLE  | car parked (dir=STAY); each tick boards one rider or picks a direction
// MOVE  | car travelling; each tick advances phase, floor changes when phase wraps
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS = 3,
    parameter int DEPTH  = 4,
    parameter int PHASES = 4,
    parameter int FW     = $clog2(FLOORS),
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     req_valid,
    input  logic [FW-1:0]            req_floor,
    output logic [FW-1:0]            cur_floor,
    output logic [1:0]               dir,
    output logic [1:0]               phase,
    output logic [FLOORS*DEPTH-1:0]  pending,
    output logic                     board_pulse,
    output logic                     req_drop
);

    localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);

    state_t          state_q, state_d;
    dir_t            dir_q, dir_d;
    dir_t            last_q, last_d;
    logic [1:0]      phase_q, phase_d;
    logic [FW-1:0]   floor_q, floor_d;
    logic            board_q, board_d;
    logic            drop_q, drop_d;

    logic [FLOORS-1:0] nz, full, inc, dec;
    logic              bad_floor;
    logic              pend_above, pend_below, here;
    logic [FW-1:0]     next_floor;
    logic              next_here, next_ahead;

    for (genvar f = 0; f < FLOORS; f++) begin : g_floor
        floor_queue #(
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_queue (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc[f]),
            .dec     (dec[f]),
            .full    (full[f]),
            .nonzero (nz[f]),
            .therm   (pending[f*DEPTH +: DEPTH])
        );
    end

    always_comb begin
        inc       = '0;
        bad_floor = (int'(req_floor) >= FLOORS);
        for (int f = 0; f < FLOORS; f++) begin
            inc[f] = req_valid && (int'(req_floor) == f);
        end
        drop_d = req_valid && (bad_floor || ((inc & full) != '0));
    end

    // next_* describe the floor the car reaches when the current phase wraps.
    always_comb begin
        pend_above = 1'b0;
        pend_below = 1'b0;
        here       = 1'b0;
        next_here  = 1'b0;
        next_ahead = 1'b0;
        next_floor = (dir_q == DIR_DOWN) ? floor_q - FW'(1) : floor_q + FW'(1);
        for (int f = 0; f < FLOORS; f++) begin
            if (f > int'(floor_q)) pend_above = pend_above | nz[f];
            if (f < int'(floor_q)) pend_below = pend_below | nz[f];
            if (f == int'(floor_q)) here = nz[f];
            if (f == int'(next_floor)) next_here = nz[f];
            if ((dir_q == DIR_UP) ? (f > int'(next_floor)) : (f < int'(next_floor))) begin
                next_ahead = next_ahead | nz[f];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        last_d  = last_q;
        phase_d = phase_q;
        floor_d = floor_q;
        board_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    if (here) begin
                        board_d = 1'b1;
                    end else if ((last_q == DIR_UP) ? pend_above : pend_below) begin
                        state_d = ST_MOVE;
                        dir_d   = last_q;
                        phase_d = '0;
                    end else if ((last_q == DIR_UP) ? pend_below : pend_above) begin
                        state_d = ST_MOVE;
                        dir_d   = (last_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                        last_d  = (last_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                        phase_d = '0;
                    end
                end
            end
            ST_MOVE: begin
                if (tick) begin
                    if (phase_q != LAST_PHASE) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        floor_d = next_floor;
                        phase_d = '0;
                        if (next_here || !next_ahead) begin
                            state_d = ST_IDLE;
                            dir_d   = DIR_STAY;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                dir_d   = DIR_STAY;
            end
        endcase
    end

    always_comb begin
        dec = '0;
        for (int f = 0; f < FLOORS; f++) begin
            dec[f] = board_d && (int'(floor_q) == f);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_STAY;
            last_q  <= DIR_UP;
            phase_q <= '0;
            floor_q <= '0;
            board_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
            phase_q <= phase_d;
            floor_q <= floor_d;
            board_q <= board_d;
            drop_q  <= drop_d;
        end
    end

    assign cur_floor   = floor_q;
    assign dir         = dir_q;
    assign phase       = phase_q;
    assign board_pulse = board_q;
    assign req_drop    = drop_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: a ride-level model checked every cycle against a
// 3-floor instance, plus directed literal checks and an 8-floor round trip.
module tb_elevator_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_floor = 2'd0;
    logic [1:0]  cur_floor, dir, phase;
    logic [11:0] pending;
    logic        board_pulse, req_drop;

    logic        tick_b = 1'b0;
    logic        req_valid_b = 1'b0;
    logic [2:0]  req_floor_b = 3'd0;
    logic [2:0]  cur_floor_b;
    logic [1:0]  dir_b, phase_b;
    logic [15:0] pending_b;
    logic        board_pulse_b, req_drop_b;

    int n_checks = 0;
    int n_errors = 0;

    int   m_cnt[4] = '{default: 0};
    int   m_floor = 0;
    int   m_dir = 0;
    int   m_last = 1;
    int   m_phase = 0;
    logic m_board = 1'b0;
    logic m_drop = 1'b0;

    elevator_scheduler #(.FLOORS(3), .DEPTH(4), .PHASES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
        .cur_floor   (cur_floor),
        .dir         (dir),
        .phase       (phase),
        .pending     (pending),
        .board_pulse (board_pulse),
        .req_drop    (req_drop)
    );

    elevator_scheduler #(.FLOORS(8), .DEPTH(2), .PHASES(2)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick_b),
        .req_valid   (req_valid_b),
        .req_floor   (req_floor_b),
        .cur_floor   (cur_floor_b),
        .dir         (dir_b),
        .phase       (phase_b),
        .pending     (pending_b),
        .board_pulse (board_pulse_b),
        .req_drop    (req_drop_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic any_riders(input int lo, input int hi);
        for (int f = lo; f <= hi; f++) begin
            if (f >= 0 && f < 3 && m_cnt[f] > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Ride-level model: floors as integers, direction as -1/0/+1.
    always @(posedge clk) begin
        logic        acc, brd, further;
        logic [11:0] exp_pend;
        logic [1:0]  exp_dir;
        if (!rst) begin
            m_cnt   = '{default: 0};
            m_floor = 0;
            m_dir   = 0;
            m_last  = 1;
            m_phase = 0;
            m_board = 1'b0;
            m_drop  = 1'b0;
        end else begin
            acc = 1'b0;
            brd = 1'b0;
            m_drop = 1'b0;
            if (req_valid) begin
                if (int'(req_floor) >= 3 || m_cnt[req_floor] >= 4) m_drop = 1'b1;
                else acc = 1'b1;
            end
            if (tick) begin
                if (m_dir == 0) begin
                    if (m_cnt[m_floor] > 0) begin
                        brd = 1'b1;
                    end else if ((m_last > 0) ? any_riders(m_floor + 1, 2) : any_riders(0, m_floor - 1)) begin
                        m_dir = m_last;
                        m_phase = 0;
                    end else if ((m_last > 0) ? any_riders(0, m_floor - 1) : any_riders(m_floor + 1, 2)) begin
                        m_last = -m_last;
                        m_dir = m_last;
                        m_phase = 0;
                    end
                end else if (m_phase < 3) begin
                    m_phase++;
                end else begin
                    m_floor += m_dir;
                    m_phase = 0;
                    further = (m_dir > 0) ? any_riders(m_floor + 1, 2) : any_riders(0, m_floor - 1);
                    if (m_cnt[m_floor] > 0 || !further) m_dir = 0;
                end
            end
            if (acc) m_cnt[req_floor]++;
            if (brd) m_cnt[m_floor]--;
            m_board = brd;
        end
        #1;
        exp_pend = '0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < m_cnt[f]; i++) exp_pend[f*4 + i] = 1'b1;
        end
        exp_dir = (m_dir > 0) ? 2'b01 : (m_dir < 0) ? 2'b10 : 2'b00;
        check("cyc_floor",   32'(cur_floor),   32'(m_floor));
        check("cyc_dir",     32'(dir),         32'(exp_dir));
        check("cyc_phase",   32'(phase),       32'(m_phase));
        check("cyc_pending", 32'(pending),     32'(exp_pend));
        check("cyc_board",   32'(board_pulse), 32'(m_board));
        check("cyc_drop",    32'(req_drop),    32'(m_drop));
    end

    task automatic step(input logic t, input logic v, input logic [1:0] f);
        @(negedge clk);
        tick = t;
        req_valid = v;
        req_floor = f;
        @(posedge clk);
        #2;
    endtask

    task automatic step_b(input logic t, input logic v, input logic [2:0] f);
        @(negedge clk);
        tick_b = t;
        req_valid_b = v;
        req_floor_b = f;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        repeat (2) step(1'b0, 1'b0, 2'd0);
        check("rst_floor",   32'(cur_floor), 32'd0);
        check("rst_dir",     32'(dir),       32'd0);
        check("rst_pending", 32'(pending),   32'd0);
        @(negedge clk) rst = 1'b1;

        step(1'b0, 1'b1, 2'd2);
        check("req2_pending", 32'(pending), 32'h100);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 2'd0);
            if (i == 1) check("t1_dir_up", 32'(dir), 32'd1);
            if (i == 5) check("t5_floor", 32'(cur_floor), 32'd1);
            if (i == 9) begin
                check("t9_floor", 32'(cur_floor), 32'd2);
                check("t9_dir",   32'(dir),       32'd0);
                check("t9_board", 32'(board_pulse), 32'd0);
            end
            if (i == 10) begin
                check("t10_board", 32'(board_pulse),   32'd1);
                check("t10_pend2", 32'(pending[11:8]), 32'd0);
            end
        end

        drops = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 2'd1);
            drops += int'(req_drop);
        end
        check("five_drops", 32'(drops),        32'd1);
        check("five_pend",  32'(pending[7:4]), 32'hF);

        step(1'b0, 1'b1, 2'd3);
        check("bad_floor_drop", 32'(req_drop), 32'd1);
        check("bad_floor_pend", 32'(pending),  32'h0F0);

        repeat (5) step(1'b1, 1'b0, 2'd0);
        check("down_floor", 32'(cur_floor), 32'd1);
        check("down_dir",   32'(dir),       32'd0);

        step(1'b1, 1'b0, 2'd0);
        check("board_a_pend", 32'(pending[7:4]), 32'h7);
        step(1'b1, 1'b1, 2'd1);
        check("co3_pend",  32'(pending[7:4]), 32'h7);
        check("co3_board", 32'(board_pulse),  32'd1);
        check("co3_drop",  32'(req_drop),     32'd0);
        step(1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b1, 2'd1);
        check("co2_pend",  32'(pending[7:4]), 32'h3);
        check("co2_board", 32'(board_pulse),  32'd1);
        check("co2_drop",  32'(req_drop),     32'd0);

        step(1'b0, 1'b1, 2'd0);
        repeat (2) step(1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b0, 2'd0);
        check("mv_dir_down", 32'(dir), 32'd2);
        step(1'b1, 1'b0, 2'd0);
        check("mv_phase", 32'(phase), 32'd1);

        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_floor",   32'(cur_floor), 32'd0);
        check("async_dir",     32'(dir),       32'd0);
        check("async_phase",   32'(phase),     32'd0);
        check("async_pending", 32'(pending),   32'd0);
        repeat (2) step(1'b1, 1'b1, 2'd2);
        check("hold_pending", 32'(pending), 32'd0);
        check("hold_dir",     32'(dir),     32'd0);
        @(negedge clk) rst = 1'b1;

        step(1'b0, 1'b1, 2'd1);
        repeat (5) step(1'b1, 1'b0, 2'd0);
        check("up1_floor", 32'(cur_floor), 32'd1);
        check("up1_dir",   32'(dir),       32'd0);
        step(1'b0, 1'b1, 2'd0);
        step(1'b0, 1'b1, 2'd2);
        step(1'b1, 1'b0, 2'd0);
        check("up1_board", 32'(board_pulse), 32'd1);
        step(1'b1, 1'b0, 2'd0);
        check("lastdir_up", 32'(dir), 32'd1);
        step(1'b0, 1'b0, 2'd0);

        step_b(1'b0, 1'b1, 3'd7);
        check("b_req7_pend", 32'(pending_b),  32'h4000);
        check("b_req7_drop", 32'(req_drop_b), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step_b(1'b1, 1'b0, 3'd0);
            if (i == 1) check("b_t1_dir", 32'(dir_b), 32'd1);
            if (i == 2) check("b_t2_phase", 32'(phase_b), 32'd1);
            if (i == 15) begin
                check("b_top_floor", 32'(cur_floor_b), 32'd7);
                check("b_top_dir",   32'(dir_b),       32'd0);
            end
            if (i == 16) begin
                check("b_top_board", 32'(board_pulse_b), 32'd1);
                check("b_top_pend",  32'(pending_b),     32'd0);
            end
        end
        step_b(1'b0, 1'b1, 3'd0);
        for (int i = 17; i <= 32; i++) begin
            step_b(1'b1, 1'b0, 3'd0);
            if (i == 17) check("b_t17_dir", 32'(dir_b), 32'd2);
            if (i == 31) begin
                check("b_bot_floor", 32'(cur_floor_b), 32'd0);
                check("b_bot_dir",   32'(dir_b),       32'd0);
            end
            if (i == 32) begin
                check("b_bot_board", 32'(board_pulse_b), 32'd1);
                check("b_bot_pend",  32'(pending_b),     32'd0);
            end
        end
        step_b(1'b0, 1'b0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
